// File: rtl/dac_core_pkg.sv
// dac_core_pkg: shared definitions for the multichannel DAC core.
// Holds the register offsets, the channel source encoding, the FSM state
// constants, the version constant and the per-channel configuration record.
// Optional feature macro used by the core: DAC_RAMP_PATTERN_EN.
package dac_core_pkg;

  localparam logic [31:0] CORE_VERSION = 32'h0001_0000;

  // Global register offsets (word addresses on the 14-bit register bus)
  localparam logic [13:0] REG_VERSION   = 14'h000;
  localparam logic [13:0] REG_ID        = 14'h001;
  localparam logic [13:0] REG_CTRL      = 14'h010;
  localparam logic [13:0] REG_STATUS    = 14'h011;
  localparam logic [13:0] REG_UNF_COUNT = 14'h012;

  // Channel c lives at 0x100 + 16*c: page in [13:8], channel in [7:4], offset in [3:0]
  localparam logic [5:0] REG_CH_PAGE  = 6'h01;
  localparam logic [3:0] CH_CFG_OFS   = 4'h0;
  localparam logic [3:0] CH_CONST_OFS = 4'h1;

  localparam int unsigned CTRL_ENABLE_BIT = 0;
  localparam int unsigned CTRL_ARM_BIT    = 1;
  localparam int unsigned STATUS_UNF_BIT  = 1;
  localparam int unsigned CH_EN_BIT       = 4;
  localparam int unsigned MAX_SW          = 16;

  typedef enum logic [1:0] {
    SRC_DMA   = 2'd0,
    SRC_ZERO  = 2'd1,
    SRC_RAMP  = 2'd2,
    SRC_CONST = 2'd3
  } src_t;

  typedef logic [1:0] fsm_state_t;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ARMED = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;

  // Per-channel configuration; cval is sized for the widest sample
  typedef struct packed {
    logic              en;
    src_t              src;
    logic [MAX_SW-1:0] cval;
  } ch_cfg_t;

  // True when addr targets register ofs of channel ch
  function automatic logic ch_reg_hit(input logic [13:0] addr,
                                      input logic [3:0]  ch,
                                      input logic [3:0]  ofs);
    return (addr[13:8] == REG_CH_PAGE) && (addr[7:4] == ch) && (addr[3:0] == ofs);
  endfunction

endpackage

// File: rtl/dac_channel_source.sv
// dac_channel_source: per-channel sample source mux and output register.
// Selects DMA, zero, ramp or constant samples for one channel and registers
// them; output is zero when the channel is disabled or the core is not in a
// RUN slot. The ramp generator exists only with DAC_RAMP_PATTERN_EN defined;
// otherwise the ramp source yields zero.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   run         - the sample taken on this edge feeds a RUN output cycle
//   underflow   - DMA underflow this cycle (DMA-sourced samples forced to 0)
//   cfg         - channel configuration (enable, source, constant)
//   dma_data    - this channel's SPC samples from DMA, sample 0 in the LSBs
//   dac_data    - registered output samples, same packing
module dac_channel_source
  import dac_core_pkg::*;
#(
  parameter int unsigned SPC = 4,
  parameter int unsigned SW  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic              underflow,
  input  ch_cfg_t           cfg,
  input  logic [SPC*SW-1:0] dma_data,
  output logic [SPC*SW-1:0] dac_data
);

  localparam int unsigned DW = SPC * SW;

  logic [DW-1:0] data_c;
  logic [DW-1:0] const_c;

  // Constant value replicated across all samples
  always_comb begin
    const_c = '0;
    for (int unsigned i = 0; i < SPC; i++) begin
      const_c[i*SW +: SW] = cfg.cval[SW-1:0];
    end
  end

`ifdef DAC_RAMP_PATTERN_EN
  logic [SW-1:0] ramp_base;
  logic [DW-1:0] ramp_c;

  // Ramp base restarts at 0 on RUN entry and advances SPC per RUN slot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ramp_base <= '0;
    end else if (!run) begin
      ramp_base <= '0;
    end else begin
      ramp_base <= ramp_base + SW'(SPC);
    end
  end

  // Sample i of the ramp is base + i, wrapping at 2^SW
  always_comb begin
    ramp_c = '0;
    for (int unsigned i = 0; i < SPC; i++) begin
      ramp_c[i*SW +: SW] = ramp_base + SW'(i);
    end
  end
`endif

  // Source mux with disable/idle gating
  always_comb begin
    data_c = '0;
    case (cfg.src)
      SRC_DMA:   data_c = underflow ? '0 : dma_data;
      SRC_ZERO:  data_c = '0;
`ifdef DAC_RAMP_PATTERN_EN
      SRC_RAMP:  data_c = ramp_c;
`else
      SRC_RAMP:  data_c = '0;
`endif
      SRC_CONST: data_c = const_c;
    endcase
    if (!run || !cfg.en) begin
      data_c = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dac_data <= '0;
    end else begin
      dac_data <= data_c;
    end
  end

endmodule

// File: rtl/dac_multichannel_core.sv
// dac_multichannel_core: register-controlled multichannel DAC data path.
// A register bus configures per-channel sources; an IDLE/ARMED/RUN FSM gates
// the stream, started by ext_sync after an arm write. DMA underflow is
// reported through a sticky status bit and a saturating counter.
// Optional feature macro: DAC_RAMP_PATTERN_EN (enables the ramp source).
// Ports:
//   up_clk, up_rstn        - clock, asynchronous active-low reset
//   ext_sync               - external start strobe
//   dma_data, dma_valid    - DMA samples (channel-major, sample 0 in LSBs)
//   dac_valid              - data request to DMA, high only in RUN
//   dac_enable             - per-channel enable
//   dac_data               - registered samples to the link layer
//   up_w*/up_r*            - register write/read bus, ack one cycle after req
module dac_multichannel_core
  import dac_core_pkg::*;
#(
  parameter int unsigned ID                  = 0,
  parameter int unsigned NUM_CHANNELS        = 4,
  parameter int unsigned SAMPLES_PER_CHANNEL = 4,
  parameter int unsigned SAMPLE_WIDTH        = 16
) (
  input  logic                                                up_clk,
  input  logic                                                up_rstn,
  input  logic                                                ext_sync,
  input  logic [NUM_CHANNELS*SAMPLES_PER_CHANNEL*SAMPLE_WIDTH-1:0] dma_data,
  input  logic                                                dma_valid,
  output logic                                                dac_valid,
  output logic [NUM_CHANNELS-1:0]                             dac_enable,
  output logic [NUM_CHANNELS*SAMPLES_PER_CHANNEL*SAMPLE_WIDTH-1:0] dac_data,
  input  logic                                                up_wreq,
  input  logic [13:0]                                         up_waddr,
  input  logic [31:0]                                         up_wdata,
  output logic                                                up_wack,
  input  logic                                                up_rreq,
  input  logic [13:0]                                         up_raddr,
  output logic [31:0]                                         up_rdata,
  output logic                                                up_rack
);

  localparam int unsigned SPC  = SAMPLES_PER_CHANNEL;
  localparam int unsigned SW   = SAMPLE_WIDTH;
  localparam int unsigned CH_W = SPC * SW;

  fsm_state_t                     state_q;
  fsm_state_t                     state_d;
  logic                           ctrl_en;
  logic                           unf_sticky;
  logic [31:0]                    unf_count;
  ch_cfg_t [NUM_CHANNELS-1:0]     ch_cfg;

  logic                           wr_ctrl;
  logic                           ctrl_clear;
  logic                           ctrl_arm;
  logic                           wr_unf_w1c;
  logic                           run_slot;
  logic [NUM_CHANNELS-1:0]        dma_sel;
  logic                           underflow;
  logic [31:0]                    rdata_c;

  // Upper write-data bits are not backed by any register
  logic unused_wdata;
  assign unused_wdata = &{1'b0, up_wdata[31:SW]};

  // Control write decode; a clearing write always wins over arm
  always_comb begin
    wr_ctrl    = up_wreq && (up_waddr == REG_CTRL);
    ctrl_clear = wr_ctrl && !up_wdata[CTRL_ENABLE_BIT];
    ctrl_arm   = wr_ctrl && up_wdata[CTRL_ARM_BIT] && up_wdata[CTRL_ENABLE_BIT] && ctrl_en;
    wr_unf_w1c = up_wreq && (up_waddr == REG_STATUS) && up_wdata[STATUS_UNF_BIT];
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (ctrl_arm) state_d = ST_ARMED;
      ST_ARMED: if (ext_sync) state_d = ST_RUN;
      ST_RUN:   state_d = ST_RUN;
      default:  state_d = ST_IDLE;
    endcase
    if (ctrl_clear) begin
      state_d = ST_IDLE;
    end
  end

  // FSM state register
  always_ff @(posedge up_clk or negedge up_rstn) begin
    if (!up_rstn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // A sample captured on this edge is presented in a RUN cycle when state_d is RUN
  assign run_slot = (state_d == ST_RUN);

  always_comb begin
    for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
      dma_sel[c] = ch_cfg[c].en && (ch_cfg[c].src == SRC_DMA);
    end
  end

  assign underflow = run_slot && !dma_valid && (|dma_sel);

  // Register read mux
  always_comb begin
    rdata_c = '0;
    case (up_raddr)
      REG_VERSION:   rdata_c = CORE_VERSION;
      REG_ID:        rdata_c = 32'(ID);
      REG_CTRL:      rdata_c = {31'd0, ctrl_en};
      REG_STATUS:    rdata_c = {30'd0, unf_sticky, (state_q == ST_RUN)};
      REG_UNF_COUNT: rdata_c = unf_count;
      default:       rdata_c = '0;
    endcase
    for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
      if (ch_reg_hit(up_raddr, 4'(c), CH_CFG_OFS)) begin
        rdata_c = {27'd0, ch_cfg[c].en, 2'd0, ch_cfg[c].src};
      end
      if (ch_reg_hit(up_raddr, 4'(c), CH_CONST_OFS)) begin
        rdata_c = 32'(ch_cfg[c].cval[SW-1:0]);
      end
    end
  end

  // Register file, bus handshake, status and dac_valid
  always_ff @(posedge up_clk or negedge up_rstn) begin
    if (!up_rstn) begin
      up_wack    <= 1'b0;
      up_rack    <= 1'b0;
      up_rdata   <= '0;
      dac_valid  <= 1'b0;
      ctrl_en    <= 1'b0;
      unf_sticky <= 1'b0;
      unf_count  <= '0;
      ch_cfg     <= '0;
    end else begin
      up_wack   <= up_wreq;
      up_rack   <= up_rreq;
      up_rdata  <= up_rreq ? rdata_c : 32'd0;
      dac_valid <= run_slot;

      if (wr_ctrl) begin
        ctrl_en <= up_wdata[CTRL_ENABLE_BIT];
      end

      // Set has priority over a simultaneous W1C
      if (underflow) begin
        unf_sticky <= 1'b1;
      end else if (wr_unf_w1c) begin
        unf_sticky <= 1'b0;
      end

      if (underflow && (unf_count != 32'hFFFF_FFFF)) begin
        unf_count <= unf_count + 32'd1;
      end

      for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
        if (up_wreq && ch_reg_hit(up_waddr, 4'(c), CH_CFG_OFS)) begin
          ch_cfg[c].en  <= up_wdata[CH_EN_BIT];
          ch_cfg[c].src <= src_t'(up_wdata[1:0]);
        end
        if (up_wreq && ch_reg_hit(up_waddr, 4'(c), CH_CONST_OFS)) begin
          ch_cfg[c].cval <= MAX_SW'(up_wdata[SW-1:0]);
        end
      end
    end
  end

  // Per-channel source and output register
  for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
    assign dac_enable[c] = ch_cfg[c].en;

    dac_channel_source #(
      .SPC (SPC),
      .SW  (SW)
    ) u_src (
      .clk       (up_clk),
      .rst_n     (up_rstn),
      .run       (run_slot),
      .underflow (underflow),
      .cfg       (ch_cfg[c]),
      .dma_data  (dma_data[c*CH_W +: CH_W]),
      .dac_data  (dac_data[c*CH_W +: CH_W])
    );
  end

endmodule

// File: tb/tb_dac_multichannel_core.sv
// tb_dac_multichannel_core: directed self-checking bench for the DAC core
// with default parameters. Inputs are driven and outputs sampled on the
// falling clock edge.
module tb_dac_multichannel_core;

  localparam int unsigned NC  = 4;
  localparam int unsigned SPC = 4;
  localparam int unsigned SW  = 16;
  localparam int unsigned CW  = SPC * SW;
  localparam int unsigned DW  = NC * CW;

  localparam logic [13:0] A_VER    = 14'h000;
  localparam logic [13:0] A_ID     = 14'h001;
  localparam logic [13:0] A_CTRL   = 14'h010;
  localparam logic [13:0] A_STATUS = 14'h011;
  localparam logic [13:0] A_UNF    = 14'h012;

  logic          up_clk = 1'b0;
  logic          up_rstn;
  logic          ext_sync;
  logic [DW-1:0] dma_data;
  logic          dma_valid;
  logic          dac_valid;
  logic [NC-1:0] dac_enable;
  logic [DW-1:0] dac_data;
  logic          up_wreq;
  logic [13:0]   up_waddr;
  logic [31:0]   up_wdata;
  logic          up_wack;
  logic          up_rreq;
  logic [13:0]   up_raddr;
  logic [31:0]   up_rdata;
  logic          up_rack;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 up_clk = ~up_clk;

  dac_multichannel_core #(
    .ID                  (0),
    .NUM_CHANNELS        (NC),
    .SAMPLES_PER_CHANNEL (SPC),
    .SAMPLE_WIDTH        (SW)
  ) dut (
    .up_clk     (up_clk),
    .up_rstn    (up_rstn),
    .ext_sync   (ext_sync),
    .dma_data   (dma_data),
    .dma_valid  (dma_valid),
    .dac_valid  (dac_valid),
    .dac_enable (dac_enable),
    .dac_data   (dac_data),
    .up_wreq    (up_wreq),
    .up_waddr   (up_waddr),
    .up_wdata   (up_wdata),
    .up_wack    (up_wack),
    .up_rreq    (up_rreq),
    .up_raddr   (up_raddr),
    .up_rdata   (up_rdata),
    .up_rack    (up_rack)
  );

  task automatic check_val(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Flat sample sequence start, start+1, ... across all channels
  function automatic logic [DW-1:0] seq_pat(input int unsigned start);
    logic [DW-1:0] v;
    v = '0;
    for (int i = 0; i < int'(NC * SPC); i++) begin
      v[i*SW +: SW] = SW'(start + 32'(i));
    end
    return v;
  endfunction

  function automatic logic [CW-1:0] ramp_exp(input int unsigned base);
    logic [CW-1:0] v;
    v = '0;
    for (int s = 0; s < int'(SPC); s++) begin
      v[s*SW +: SW] = SW'(base + 32'(s));
    end
    return v;
  endfunction

  function automatic logic [CW-1:0] ch_slice(input logic [DW-1:0] d, input int c);
    return d[c*CW +: CW];
  endfunction

  task automatic reg_wr(input logic [13:0] a, input logic [31:0] d);
    @(negedge up_clk);
    up_wreq  = 1'b1;
    up_waddr = a;
    up_wdata = d;
    @(negedge up_clk);
    up_wreq = 1'b0;
    check_val("wack", DW'(up_wack), DW'(1'b1));
  endtask

  task automatic reg_rd(input string tag, input logic [13:0] a, input logic [31:0] exp);
    @(negedge up_clk);
    up_rreq  = 1'b1;
    up_raddr = a;
    @(negedge up_clk);
    up_rreq = 1'b0;
    check_val("rack", DW'(up_rack), DW'(1'b1));
    check_val(tag, DW'(up_rdata), DW'(exp));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] exp;
    logic [CW-1:0] expc;

    up_rstn   = 1'b0;
    ext_sync  = 1'b0;
    dma_data  = '0;
    dma_valid = 1'b1;
    up_wreq   = 1'b0;
    up_waddr  = '0;
    up_wdata  = '0;
    up_rreq   = 1'b0;
    up_raddr  = '0;

    // Reset state
    repeat (3) @(negedge up_clk);
    check_val("rst_valid", DW'(dac_valid), DW'(1'b0));
    check_val("rst_enable", DW'(dac_enable), DW'(4'h0));
    check_val("rst_data", dac_data, '0);
    check_val("rst_wack", DW'(up_wack), DW'(1'b0));
    check_val("rst_rack", DW'(up_rack), DW'(1'b0));
    check_val("rst_rdata", DW'(up_rdata), DW'(32'h0));
    up_rstn = 1'b1;

    reg_rd("version", A_VER, 32'h0001_0000);
    reg_rd("id", A_ID, 32'h0);
    reg_rd("ch0_cfg_default", 14'h100, 32'h0);
    reg_rd("unmapped", 14'h055, 32'h0);
    @(negedge up_clk);
    check_val("rdata_idle", DW'(up_rdata), DW'(32'h0));
    check_val("rack_idle", DW'(up_rack), DW'(1'b0));

    // DMA passthrough on all channels
    for (int c = 0; c < int'(NC); c++) reg_wr(14'h100 + 14'(16 * c), 32'h10);
    check_val("enable_all", DW'(dac_enable), DW'(4'hF));
    reg_wr(A_CTRL, 32'h1);
    reg_wr(A_CTRL, 32'h3);
    reg_rd("status_armed", A_STATUS, 32'h0);
    @(negedge up_clk);
    check_val("armed_valid", DW'(dac_valid), DW'(1'b0));
    ext_sync = 1'b1;
    dma_data = seq_pat(1);
    exp      = dma_data;
    for (int k = 0; k < 4; k++) begin
      @(negedge up_clk);
      ext_sync = 1'b0;
      check_val("run_valid", DW'(dac_valid), DW'(1'b1));
      check_val("dma_pass", dac_data, exp);
      dma_data = seq_pat(32'(17 + 16 * k));
      exp      = dma_data;
    end

    // Underflow for three cycles
    dma_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge up_clk);
      check_val("unf_zero", dac_data, '0);
    end
    dma_valid = 1'b1;
    dma_data  = seq_pat(32'h500);
    exp       = dma_data;
    @(negedge up_clk);
    check_val("unf_recover", dac_data, exp);
    reg_rd("unf_count", A_UNF, 32'd3);
    reg_rd("status_unf", A_STATUS, 32'h3);
    reg_wr(A_STATUS, 32'h2);
    reg_rd("status_w1c", A_STATUS, 32'h1);
    reg_rd("unf_count_kept", A_UNF, 32'd3);

    // Channel 2 constant, channel 3 disabled
    reg_wr(14'h121, 32'h1234);
    reg_wr(14'h120, 32'h13);
    reg_wr(14'h130, 32'h00);
    @(negedge up_clk);
    check_val("enable_7", DW'(dac_enable), DW'(4'h7));
    check_val("ch2_const", DW'(ch_slice(dac_data, 2)), DW'({4{16'h1234}}));
    check_val("ch3_off", DW'(ch_slice(dac_data, 3)), '0);
    check_val("ch0_dma", DW'(ch_slice(dac_data, 0)), DW'(ch_slice(exp, 0)));
    reg_rd("ch2_const_rd", 14'h121, 32'h1234);
    reg_rd("ch2_cfg_rd", 14'h120, 32'h13);

    // Stop, then ramp on channel 1 across a full wrap
    reg_wr(A_CTRL, 32'h0);
    check_val("stop_valid", DW'(dac_valid), DW'(1'b0));
    check_val("stop_data", dac_data, '0);
    reg_rd("status_idle", A_STATUS, 32'h0);
    reg_wr(14'h110, 32'h12);
    reg_wr(A_CTRL, 32'h1);
    reg_wr(A_CTRL, 32'h3);
    @(negedge up_clk);
    ext_sync = 1'b1;
    for (int k = 0; k < 32'h4004; k++) begin
      @(negedge up_clk);
      ext_sync = 1'b0;
`ifdef DAC_RAMP_PATTERN_EN
      expc = ramp_exp(32'(4 * k));
`else
      expc = '0;
`endif
      check_val("ch1_ramp", DW'(ch_slice(dac_data, 1)), DW'(expc));
    end

    // Arm together with enable clear stays idle
    reg_wr(A_CTRL, 32'h0);
    reg_wr(A_CTRL, 32'h1);
    reg_wr(A_CTRL, 32'h2);
    @(negedge up_clk);
    ext_sync = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge up_clk);
      ext_sync = 1'b0;
      check_val("arm_clear_valid", DW'(dac_valid), DW'(1'b0));
    end
    reg_rd("arm_clear_status", A_STATUS, 32'h0);
    reg_rd("arm_clear_ctrl", A_CTRL, 32'h0);

    // Reset pulse in RUN with a write request in flight
    reg_wr(A_CTRL, 32'h1);
    reg_wr(A_CTRL, 32'h3);
    @(negedge up_clk);
    ext_sync = 1'b1;
    @(negedge up_clk);
    ext_sync = 1'b0;
    check_val("pre_rst_valid", DW'(dac_valid), DW'(1'b1));
    check_val("pre_rst_ch0", DW'(ch_slice(dac_data, 0)), DW'(ch_slice(dma_data, 0)));
    up_wreq  = 1'b1;
    up_waddr = A_CTRL;
    up_wdata = 32'h0;
    #2;
    up_rstn = 1'b0;
    #1;
    check_val("mid_rst_valid", DW'(dac_valid), DW'(1'b0));
    check_val("mid_rst_data", dac_data, '0);
    check_val("mid_rst_enable", DW'(dac_enable), DW'(4'h0));
    @(negedge up_clk);
    up_wreq = 1'b0;
    @(negedge up_clk);
    up_rstn = 1'b1;
    @(negedge up_clk);
    check_val("post_rst_wack", DW'(up_wack), DW'(1'b0));
    check_val("post_rst_rack", DW'(up_rack), DW'(1'b0));
    check_val("post_rst_valid", DW'(dac_valid), DW'(1'b0));
    check_val("post_rst_data", dac_data, '0);
    reg_rd("post_rst_version", A_VER, 32'h0001_0000);
    reg_rd("post_rst_ctrl", A_CTRL, 32'h0);
    reg_rd("post_rst_status", A_STATUS, 32'h0);
    reg_rd("post_rst_unf", A_UNF, 32'h0);
    reg_rd("post_rst_ch1_cfg", 14'h110, 32'h0);
    reg_rd("post_rst_ch2_const", 14'h121, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
